pq_server: RTL and testbench

PQ_SERVER -- requirements
Module: pq_server

---
 rtl/pq_pkg.sv | 19 +
 rtl/pq_cell.sv | 48 ++++
 rtl/pq_server.sv | 119 +++++++++++
 tb/tb_pq_server.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the min-first priority queue.
// Entry layout, default depth and control states.
package pq_pkg;

    localparam int PQ_DEPTH = 8;

    typedef struct packed {
        logic [7:0] key;
        logic [7:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        IDLE,
        INS,
        REM,
        RPL
    } state_t;

endpackage

// File: rtl/pq_cell.sv
// One slot of the sorted array: register, key compare
// against the held entry, and source select for loading.
module pq_cell
    import pq_pkg::*;
#(
    parameter bit FIRST = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t st,
    input  kv_t    hold,
    input  kv_t    prev,
    input  kv_t    nxt,
    input  logic   le_prev,
    input  logic   le_next,
    input  logic   valid,
    output kv_t    q,
    output logic   le
);

    // Occupied and ordered at or before the held entry.
    assign le = valid && (q.key <= hold.key);

    // Keep, take the held entry, or shift from a neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            unique case (st)
                INS: begin
                    if (!le) begin
                        q <= (FIRST || le_prev) ? hold : prev;
                    end
                end
                REM: q <= nxt;
                RPL: begin
                    if (le_next) begin
                        q <= nxt;
                    end else if (FIRST || le) begin
                        q <= hold;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pq_server.sv
// Sorted-array priority queue, smallest key at the head.
// One operation per two cycles; ties leave in arrival order.
module pq_server
    import pq_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  kv_t                        kvi,
    output kv_t                        kvo,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t         st;
    state_t         st_nxt;
    kv_t            hold;
    logic [CW-1:0]  cnt;
    kv_t            ent [DEPTH];
    kv_t            prv [DEPTH];
    kv_t            nx  [DEPTH];
    logic [DEPTH-1:0] le;
    logic [DEPTH-1:0] lp;
    logic [DEPTH-1:0] ln;
    logic           is_full;
    logic           is_empty;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);

    // Choose the operation for a request seen while idle.
    always_comb begin
        st_nxt = IDLE;
        if (st == IDLE) begin
            unique case (1'b1)
                enq && !deq && !is_full:  st_nxt = INS;
                deq && !enq && !is_empty: st_nxt = REM;
                enq && deq && !is_empty:  st_nxt = RPL;
                enq && deq && is_empty:   st_nxt = INS;
                default:                  st_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Capture the incoming entry on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else if (st == IDLE && st_nxt != IDLE) begin
            hold <= kvi;
        end
    end

    // Occupancy follows the operation being executed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (st == INS) begin
            cnt <= cnt + CW'(1);
        end else if (st == REM) begin
            cnt <= cnt - CW'(1);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        if (gi == 0) begin : g_lo
            assign prv[gi] = '0;
            assign lp[gi]  = 1'b1;
        end else begin : g_lo
            assign prv[gi] = ent[gi-1];
            assign lp[gi]  = le[gi-1];
        end
        if (gi == DEPTH - 1) begin : g_hi
            assign nx[gi] = '0;
            assign ln[gi] = 1'b0;
        end else begin : g_hi
            assign nx[gi] = ent[gi+1];
            assign ln[gi] = le[gi+1];
        end
        pq_cell #(
            .FIRST (gi == 0)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .st      (st),
            .hold    (hold),
            .prev    (prv[gi]),
            .nxt     (nx[gi]),
            .le_prev (lp[gi]),
            .le_next (ln[gi]),
            .valid   (CW'(gi) < cnt),
            .q       (ent[gi]),
            .le      (le[gi])
        );
    end

    assign kvo   = is_empty ? '0 : ent[0];
    assign full  = is_full;
    assign empty = is_empty;
    assign busy  = (st != IDLE);
    assign count = cnt;

endmodule

// File: tb/tb_pq_server.sv
// Bench for pq_server: queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pq_server;
    import pq_pkg::*;

    logic       clk;
    logic       rst;
    logic       enq;
    logic       deq;
    kv_t        kvi;
    kv_t        kvo;
    logic       full;
    logic       empty;
    logic       busy;
    logic [3:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    kv_t mq[$];
    bit  mbusy = 0;
    int  mop   = 0;
    kv_t mhold;

    pq_server #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .kvi   (kvi),
        .kvo   (kvo),
        .full  (full),
        .empty (empty),
        .busy  (busy),
        .count (count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h",
                      nm, act, exp);
    endtask

    // New entry goes after every stored key <= its key.
    function automatic void m_ins(input kv_t x);
        int p = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].key > x.key) p = i;
        end
        mq.insert(p, x);
    endfunction

    // Reference queue: one accepted op, done next edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mbusy = 0;
        end else if (mbusy) begin
            if (mop == 1) m_ins(mhold);
            if (mop == 2) void'(mq.pop_front());
            if (mop == 3) begin
                void'(mq.pop_front());
                m_ins(mhold);
            end
            mbusy = 0;
        end else begin
            mop = 0;
            if (enq && deq)
                mop = (mq.size() == 0) ? 1 : 3;
            else if (enq && mq.size() < 8)
                mop = 1;
            else if (deq && mq.size() > 0)
                mop = 2;
            if (mop != 0) begin
                mhold = kvi;
                mbusy = 1;
            end
        end
    end

    // Compare every cycle against the reference.
    always @(negedge clk) begin
        chk("kvo", kvo,
            mq.size() != 0 ? mq[0] : 16'h0000);
        chk("count", 16'(count), 16'(mq.size()));
        chk("full", 16'(full), 16'(mq.size() == 8));
        chk("empty", 16'(empty), 16'(mq.size() == 0));
        chk("busy", 16'(busy), 16'(mbusy));
    end

    task automatic op(input logic e, input logic d,
                      input logic [15:0] kv);
        @(posedge clk); #2;
        enq = e; deq = d; kvi = kv;
        @(posedge clk); #2;
        enq = 0; deq = 0; kvi = 16'hDEAD;
        @(posedge clk); #2;
    endtask

    logic [15:0] fill  [8] = '{
        16'h8001, 16'h2002, 16'h5003, 16'h2004,
        16'hF005, 16'h0106, 16'hFF07, 16'h2008
    };
    logic [15:0] drain [8] = '{
        16'h2002, 16'h2004, 16'h2008, 16'h5003,
        16'h8001, 16'hF005, 16'hFF07, 16'h0000
    };

    initial begin
        rst = 1; enq = 0; deq = 0; kvi = '0;
        #1 rst = 0;
        #1;
        chk("rst_kvo", kvo, 16'h0000);
        chk("rst_empty", 16'(empty), 16'h1);
        chk("rst_full", 16'(full), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_count", 16'(count), 16'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1;

        op(1, 0, 16'h1E1E);
        op(1, 0, 16'h0A0A);
        op(1, 0, 16'h1414);
        chk("ord_head", kvo, 16'h0A0A);
        chk("ord_cnt", 16'(count), 16'h3);
        op(0, 1, 16'h0);
        chk("ord_d1", kvo, 16'h1414);
        op(0, 1, 16'h0);
        chk("ord_d2", kvo, 16'h1E1E);
        op(0, 1, 16'h0);
        chk("ord_d3", kvo, 16'h0000);
        chk("ord_empty", 16'(empty), 16'h1);

        op(1, 0, 16'h0501);
        op(1, 0, 16'h0502);
        chk("tie_head", kvo, 16'h0501);
        op(0, 1, 16'h0);
        chk("tie_d1", kvo, 16'h0502);
        op(0, 1, 16'h0);
        chk("tie_d2", kvo, 16'h0000);

        op(0, 1, 16'h0);
        chk("uflow_cnt", 16'(count), 16'h0);
        chk("uflow_empty", 16'(empty), 16'h1);

        for (int i = 0; i < 8; i++) op(1, 0, fill[i]);
        chk("fill_full", 16'(full), 16'h1);
        chk("fill_cnt", 16'(count), 16'h8);
        chk("fill_head", kvo, 16'h0106);
        @(posedge clk); #2;
        enq = 1; kvi = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ovf_busy", 16'(busy), 16'h0);
            #1;
        end
        enq = 0;
        chk("ovf_cnt", 16'(count), 16'h8);
        chk("ovf_head", kvo, 16'h0106);
        chk("ovf_full", 16'(full), 16'h1);

        op(1, 1, 16'h0009);
        chk("rplf_head", kvo, 16'h0009);
        chk("rplf_cnt", 16'(count), 16'h8);
        for (int i = 0; i < 8; i++) begin
            op(0, 1, 16'h0);
            chk("drain", kvo, drain[i]);
        end
        chk("drain_empty", 16'(empty), 16'h1);

        op(1, 0, 16'h0A01);
        op(1, 0, 16'h2802);
        op(1, 1, 16'h1403);
        chk("rpl_head", kvo, 16'h1403);
        chk("rpl_cnt", 16'(count), 16'h2);

        @(posedge clk); #2;
        enq = 1; kvi = 16'h3333;
        @(posedge clk); #2;
        kvi = 16'h4444;
        @(posedge clk); #2;
        enq = 0;
        @(posedge clk); #2;
        chk("busy_drop_cnt", 16'(count), 16'h3);
        chk("busy_drop_head", kvo, 16'h1403);

        @(posedge clk); #2;
        enq = 1; kvi = 16'h0505;
        @(posedge clk); #2;
        enq = 0;
        chk("mid_busy", 16'(busy), 16'h1);
        #1 rst = 0;
        #1;
        chk("mid_kvo", kvo, 16'h0000);
        chk("mid_cnt", 16'(count), 16'h0);
        chk("mid_empty", 16'(empty), 16'h1);
        chk("mid_busy0", 16'(busy), 16'h0);
        chk("mid_full", 16'(full), 16'h0);
        @(posedge clk); #2 rst = 1;
        op(1, 0, 16'h7F7F);
        chk("post_head", kvo, 16'h7F7F);
        chk("post_cnt", 16'(count), 16'h1);

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
